r5_serializer: RTL and testbench

Radix-5 butterfly output serializer. Accepts one frame of five parallel complex samples from the radix-5 butterfly and emits them one per cycle on a single complex stream, index 0 first, with valid/ready flow control on both sides. It performs the reverse of the input-side delay-line alignment: the delay line spreads a serial stream across five butterfly taps, and this block collapses the five butterfly outputs back to serial for the next stage or the output memory.

---
 rtl/r5_serializer_if.sv | 26 ++
 rtl/r5_serializer.sv | 88 ++++++++
 tb/tb_r5_serializer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/r5_serializer_if.sv
// Handshake/bus bundle for r5_serializer: parallel 5-sample frame in, serial complex stream out.
// slave = the serializer's view, master = the upstream/downstream environment's view.
interface r5_serializer_if #(
    parameter int DW = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [5*DW-1:0]      x_re;
    logic [5*DW-1:0]      x_img;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] y_re;
    logic signed [DW-1:0] y_img;
    logic [2:0]           y_idx;
    logic                 y_last;

    modport master (
        output in_valid, x_re, x_img, out_ready,
        input  in_ready, out_valid, y_re, y_img, y_idx, y_last
    );

    modport slave (
        input  in_valid, x_re, x_img, out_ready,
        output in_ready, out_valid, y_re, y_img, y_idx, y_last
    );
endinterface

// File: rtl/r5_serializer.sv
// Radix-5 butterfly output serializer: one 5-sample complex frame in, one sample per cycle out.
// Optional build macro R5_SER_CONJ_EN conjugates the output stream (y_img negated, wrapping).
module r5_serializer #(
    parameter int DW = 32
) (
    input logic            clk,
    input logic            rst,
    r5_serializer_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, DRAIN = 1'b1} state_t;

    localparam logic [2:0] LAST_IDX = 3'd4;

    state_t               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic signed [DW-1:0] hold_re_q  [5];
    logic signed [DW-1:0] hold_img_q [5];
    logic                 last_beat;
    logic                 load;

`ifdef R5_SER_CONJ_EN
    // Two's complement negate at DW bits; the most negative value maps to itself.
    function automatic logic signed [DW-1:0] conj_wrap(input logic signed [DW-1:0] v);
        return -v;
    endfunction
`endif

    // The last beat frees the holding register in the same cycle, enabling zero-bubble frames.
    assign last_beat = (state_q == DRAIN) && (idx_q == LAST_IDX) && bus.out_ready;
    assign load      = bus.in_valid && ((state_q == EMPTY) || last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            for (int k = 0; k < 5; k++) begin
                hold_re_q[k]  <= '0;
                hold_img_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                for (int k = 0; k < 5; k++) begin
                    hold_re_q[k]  <= bus.x_re[k*DW +: DW];
                    hold_img_q[k] <= bus.x_img[k*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            EMPTY: begin
                if (bus.in_valid) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        idx_d   = '0;
                        state_d = bus.in_valid ? DRAIN : EMPTY;
                    end
                end
            end
        endcase
    end

    // Outputs depend only on registered state and out_ready (for in_ready); no in_valid path.
    always_comb begin
        bus.in_ready  = (state_q == EMPTY) || last_beat;
        bus.out_valid = (state_q == DRAIN);
        bus.y_idx     = (state_q == DRAIN) ? idx_q : 3'd0;
        bus.y_last    = (state_q == DRAIN) && (idx_q == LAST_IDX);
        bus.y_re      = hold_re_q[idx_q];
`ifdef R5_SER_CONJ_EN
        bus.y_img     = conj_wrap(hold_img_q[idx_q]);
`else
        bus.y_img     = hold_img_q[idx_q];
`endif
    end
endmodule

// File: tb/tb_r5_serializer.sv
// Self-checking bench for r5_serializer: scoreboard of expected beats plus directed timing checks.
// Honours R5_SER_CONJ_EN for the expected imaginary values.
module tb_r5_serializer;
    localparam int DW = 32;

`ifdef R5_SER_CONJ_EN
    localparam logic [31:0] EXT0 = 32'h8000_0000;
    localparam logic [31:0] EXT1 = 32'h8000_0001;
`else
    localparam logic [31:0] EXT0 = 32'h8000_0000;
    localparam logic [31:0] EXT1 = 32'h7FFF_FFFF;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    r5_serializer_if #(.DW(DW)) bus ();
    r5_serializer #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] img;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_img(input logic [31:0] v);
`ifdef R5_SER_CONJ_EN
        return 32'd0 - v;
`else
        return v;
`endif
    endfunction

    function automatic logic [159:0] pack5(input logic [31:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [159:0] re, input logic [159:0] im);
        bus.x_re     = re;
        bus.x_img    = im;
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, bus.out_valid}, 32'd0);
    endtask

    // Scoreboard: push on accepted frames, pop on accepted output beats.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                check_eq("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    beat_t b;
                    b = sb.pop_front();
                    check_eq("sb_re",   bus.y_re,            b.re);
                    check_eq("sb_img",  bus.y_img,           b.img);
                    check_eq("sb_idx",  {29'd0, bus.y_idx},  {29'd0, b.idx});
                    check_eq("sb_last", {31'd0, bus.y_last}, {31'd0, b.last});
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int k = 0; k < 5; k++) begin
                    beat_t nb;
                    nb.re   = bus.x_re[k*32 +: 32];
                    nb.img  = exp_img(bus.x_img[k*32 +: 32]);
                    nb.idx  = 3'(k);
                    nb.last = (k == 4);
                    sb.push_back(nb);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x_re      = '0;
        bus.x_img     = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_y_re",      bus.y_re,               32'd0);
        check_eq("rst_y_img",     bus.y_img,              32'd0);
        check_eq("rst_y_idx",     {29'd0, bus.y_idx},     32'd0);
        check_eq("rst_y_last",    {31'd0, bus.y_last},    32'd0);
        tick();
        rst = 1'b0;

        // Single frame, latency and ordering
        load(pack5(1, 2, 3, 4, 5), pack5(10, 20, 30, 40, 50));
        @(negedge clk);
        check_eq("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("t1_valid", {31'd0, bus.out_valid}, 32'd1);
            check_eq("t1_idx",   {29'd0, bus.y_idx},     32'(k));
            check_eq("t1_last",  {31'd0, bus.y_last},    {31'd0, k == 4});
            check_eq("t1_re",    bus.y_re,               32'(k + 1));
            check_eq("t1_img",   bus.y_img,              exp_img(32'(10 * (k + 1))));
        end
        @(negedge clk);
        check_eq("t1_idle_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("t1_idle_idx",   {29'd0, bus.y_idx},     32'd0);

        // Back-to-back frames A then B
        tick();
        load(pack5(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4), pack5(32'h100, 32'h101, 32'h102, 32'h103, 32'h104));
        vcount = 0;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 9) check_eq("t2_in_ready", {31'd0, bus.in_ready}, {31'd0, (c == 0) || (c == 5)});
            if (c >= 1) vcount += int'(bus.out_valid);
            if (c == 6) check_eq("t2_b0_idx", {29'd0, bus.y_idx}, 32'd0);
            @(posedge clk);
            #1;
            if (c == 0) load(pack5(32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4), pack5(32'hFFFF_FF00, 32'hFFFF_FF01, 32'h7, 32'h8, 32'h9));
            if (c == 5) bus.in_valid = 1'b0;
        end
        check_eq("t2_beats", 32'(vcount), 32'd10);
        @(negedge clk);
        check_eq("t2_idle", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure on sample 2 for three cycles
        tick();
        load(pack5(32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4), pack5(32'h200, 32'h201, 32'h202, 32'h203, 32'h204));
        @(negedge clk);
        tick();
        bus.in_valid = 1'b0;
        vcount = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (!bus.out_valid) break;
            vcount++;
            if (c >= 2 && c <= 4) begin
                check_eq("t3_idx",      {29'd0, bus.y_idx},    32'd2);
                check_eq("t3_in_ready", {31'd0, bus.in_ready}, 32'd0);
                check_eq("t3_re",       bus.y_re,              32'hC2);
                check_eq("t3_img",      bus.y_img,             exp_img(32'h202));
            end
            @(posedge clk);
            #1;
            if (c == 1) bus.out_ready = 1'b0;
            if (c == 4) bus.out_ready = 1'b1;
        end
        check_eq("t3_frame_cycles", 32'(vcount), 32'd8);

        // Upstream hold: new frame offered while idx=1
        tick();
        load(pack5(32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4), pack5(32'h300, 32'h301, 32'h302, 32'h303, 32'h304));
        @(negedge clk);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        tick();
        load(pack5(32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4), pack5(32'h400, 32'h401, 32'h402, 32'h403, 32'h404));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_eq("t4_idx",      {29'd0, bus.y_idx},    32'(i));
            check_eq("t4_in_ready", {31'd0, bus.in_ready}, {31'd0, i == 4});
            check_eq("t4_re",       bus.y_re,              32'(32'hD0 + i));
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_e0_idx", {29'd0, bus.y_idx}, 32'd0);
        check_eq("t4_e0_re",  bus.y_re,           32'hE0);
        wait_idle("t4_drain_timeout");

        // Reset asserted at idx=2
        tick();
        load(pack5(32'hF0, 32'hF1, 32'hF2, 32'hF3, 32'hF4), pack5(32'h500, 32'h501, 32'h502, 32'h503, 32'h504));
        @(negedge clk);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        check_eq("t5_pre_idx", {29'd0, bus.y_idx}, 32'd2);
        #1 rst = 1'b1;
        #1;
        check_eq("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("t5_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check_eq("t5_y_re",      bus.y_re,               32'd0);
        check_eq("t5_y_img",     bus.y_img,              32'd0);
        check_eq("t5_y_idx",     {29'd0, bus.y_idx},     32'd0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_no_partial", {31'd0, bus.out_valid}, 32'd0);
        tick();
        load(pack5(32'h10, 32'h11, 32'h12, 32'h13, 32'h14), pack5(32'h600, 32'h601, 32'h602, 32'h603, 32'h604));
        @(negedge clk);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_restart_idx", {29'd0, bus.y_idx}, 32'd0);
        check_eq("t5_restart_re",  bus.y_re,           32'h10);
        wait_idle("t5_drain_timeout");

        // Extreme imaginary values
        tick();
        load(pack5(1, 2, 3, 4, 5), pack5(32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFF));
        @(negedge clk);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("t6_img0", bus.y_img, EXT0);
        tick();
        @(negedge clk);
        check_eq("t6_img1", bus.y_img, EXT1);
        wait_idle("t6_drain_timeout");

        @(negedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
